// File: rtl/fifo_pkg.sv
// Shared sizing helpers and the bundled status type for the synchronous FIFO family.
package fifo_pkg;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A depth of 1 would give a zero-width pointer, so it is clamped to one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst_i,
    input  logic                          wr_en_i,
    input  logic [ptr_width(DEPTH)-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic                          rd_en_i,
    input  logic [ptr_width(DEPTH)-1:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0]         rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto RAM; only written entries are ever read.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read-before-write: a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO: circular buffer with registered read data,
// occupancy count, threshold flags and sticky overflow/underflow errors.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          rd_valid,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic pop_ok, push_ok, wr_en, rd_en;

    // Explicit compare so non-power-of-2 depths wrap correctly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_CNT);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;
    assign rd_valid     = rd_valid_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign wr_en   = push_ok && !flush;
    assign rd_en   = pop_ok && !flush;

    // NOTE: every next-state signal gets its default first so no latch is inferred.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = rd_en;
        overflow_d  = overflow_q | (push && !push_ok && !flush);
        underflow_d = underflow_q | (pop && empty && !flush);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = next_ptr(wr_ptr_q);
            if (rd_en) rd_ptr_d = next_ptr(rd_ptr_q);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk       (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_in),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (data_out)
    );

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: DEPTH=4 and DEPTH=5 instances, read data
// checked by per-instance scoreboard monitors, flags checked directly.
module tb_fifo_sync_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       a_rst, a_flush, a_push, a_pop;
    logic [7:0] a_din, a_dout;
    logic       a_rd_valid, a_empty, a_full, a_af, a_ae, a_ov, a_un;
    logic [2:0] a_count;

    logic       b_rst, b_flush, b_push, b_pop;
    logic [7:0] b_din, b_dout;
    logic       b_rd_valid, b_empty, b_full, b_af, b_ae, b_ov, b_un;
    logic [2:0] b_count;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(4)) dut_a (
        .clk(clk), .rst(a_rst), .flush(a_flush), .push(a_push), .data_in(a_din),
        .pop(a_pop), .data_out(a_dout), .rd_valid(a_rd_valid), .empty(a_empty),
        .full(a_full), .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ov), .underflow(a_un)
    );

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(5)) dut_b (
        .clk(clk), .rst(b_rst), .flush(b_flush), .push(b_push), .data_in(b_din),
        .pop(b_pop), .data_out(b_dout), .rd_valid(b_rd_valid), .empty(b_empty),
        .full(b_full), .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ov), .underflow(b_un)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every rd_valid strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (a_rd_valid === 1'b1) begin
            if (qa.size() == 0) check("a_rd_unexpected", 32'd1, 32'd0);
            else check("a_data_out", a_dout, qa.pop_front());
        end
    end

    always @(negedge clk) begin
        if (b_rd_valid === 1'b1) begin
            if (qb.size() == 0) check("b_rd_unexpected", 32'd1, 32'd0);
            else check("b_data_out", b_dout, qb.pop_front());
        end
    end

    // One clock of stimulus on instance sel (0=A, 1=B); the other instance idles.
    task automatic cyc(input bit sel, input bit rst, input bit flush, input bit push,
                       input logic [7:0] din, input bit pop, input bit exp_rd,
                       input logic [7:0] exp_d);
        a_rst = 0; a_flush = 0; a_push = 0; a_pop = 0; a_din = '0;
        b_rst = 0; b_flush = 0; b_push = 0; b_pop = 0; b_din = '0;
        if (!sel) begin
            a_rst = rst; a_flush = flush; a_push = push; a_din = din; a_pop = pop;
            if (exp_rd) qa.push_back(exp_d);
        end else begin
            b_rst = rst; b_flush = flush; b_push = push; b_din = din; b_pop = pop;
            if (exp_rd) qb.push_back(exp_d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic psh(input bit sel, input logic [7:0] d);
        cyc(sel, 0, 0, 1, d, 0, 0, '0);
    endtask

    task automatic pp(input bit sel, input logic [7:0] exp_d);
        cyc(sel, 0, 0, 0, '0, 1, 1, exp_d);
    endtask

    task automatic chk(input bit sel, input int cnt, input bit e, input bit f,
                       input bit ae, input bit af, input bit ov, input bit un);
        if (!sel) begin
            check("a_count", 32'(a_count), cnt);
            check("a_empty", 32'(a_empty), 32'(e));
            check("a_full", 32'(a_full), 32'(f));
            check("a_almost_empty", 32'(a_ae), 32'(ae));
            check("a_almost_full", 32'(a_af), 32'(af));
            check("a_overflow", 32'(a_ov), 32'(ov));
            check("a_underflow", 32'(a_un), 32'(un));
        end else begin
            check("b_count", 32'(b_count), cnt);
            check("b_empty", 32'(b_empty), 32'(e));
            check("b_full", 32'(b_full), 32'(f));
            check("b_almost_empty", 32'(b_ae), 32'(ae));
            check("b_almost_full", 32'(b_af), 32'(af));
            check("b_overflow", 32'(b_ov), 32'(ov));
            check("b_underflow", 32'(b_un), 32'(un));
        end
    endtask

    initial begin
        a_rst = 1; a_flush = 0; a_push = 0; a_pop = 0; a_din = '0;
        b_rst = 1; b_flush = 0; b_push = 0; b_pop = 0; b_din = '0;
        @(posedge clk);
        #1;

        // Reset state, both instances
        chk(0, 0, 1, 0, 1, 0, 0, 0);
        check("a_rst_rd_valid", 32'(a_rd_valid), 0);
        check("a_rst_data_out", 32'(a_dout), 0);
        chk(1, 0, 1, 0, 1, 0, 0, 0);
        check("b_rst_data_out", 32'(b_dout), 0);

        // A: fill to full, then drain in order
        psh(0, 8'h11); chk(0, 1, 0, 0, 1, 0, 0, 0);
        psh(0, 8'h22); chk(0, 2, 0, 0, 0, 0, 0, 0);
        psh(0, 8'h33); chk(0, 3, 0, 0, 0, 1, 0, 0);
        psh(0, 8'h44); chk(0, 4, 0, 1, 0, 1, 0, 0);
        pp(0, 8'h11);
        check("a_rd_valid_after_pop", 32'(a_rd_valid), 1);
        chk(0, 3, 0, 0, 0, 1, 0, 0);
        pp(0, 8'h22); pp(0, 8'h33); pp(0, 8'h44);
        chk(0, 0, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, '0, 0, 0, '0);
        check("a_rd_valid_idle", 32'(a_rd_valid), 0);
        check("a_data_out_hold", 32'(a_dout), 32'h44);

        // A: interleaved push/pop across pointer wrap
        psh(0, 8'hA1); psh(0, 8'hA2); psh(0, 8'hA3);
        pp(0, 8'hA1); pp(0, 8'hA2);
        psh(0, 8'hA4); psh(0, 8'hA5); psh(0, 8'hA6);
        chk(0, 4, 0, 1, 0, 1, 0, 0);
        pp(0, 8'hA3); pp(0, 8'hA4); pp(0, 8'hA5); pp(0, 8'hA6);
        chk(0, 0, 1, 0, 1, 0, 0, 0);

        // A: simultaneous push/pop on full, then dropped push
        psh(0, 8'hB1); psh(0, 8'hB2); psh(0, 8'hB3); psh(0, 8'hB4);
        cyc(0, 0, 0, 1, 8'h55, 1, 1, 8'hB1);
        chk(0, 4, 0, 1, 0, 1, 0, 0);
        psh(0, 8'h66);
        chk(0, 4, 0, 1, 0, 1, 1, 0);
        pp(0, 8'hB2);
        chk(0, 3, 0, 0, 0, 1, 1, 0);

        // A: flush with concurrent push and pop
        cyc(0, 0, 1, 1, 8'h99, 1, 0, '0);
        chk(0, 0, 1, 0, 1, 0, 1, 0);
        check("a_flush_rd_valid", 32'(a_rd_valid), 0);
        check("a_flush_data_hold", 32'(a_dout), 32'hB2);
        psh(0, 8'h77); pp(0, 8'h77);
        chk(0, 0, 1, 0, 1, 0, 1, 0);

        // A: pop on empty, then push+pop on empty
        cyc(0, 0, 0, 0, '0, 1, 0, '0);
        chk(0, 0, 1, 0, 1, 0, 1, 1);
        check("a_empty_pop_rd_valid", 32'(a_rd_valid), 0);
        check("a_empty_pop_data_hold", 32'(a_dout), 32'h77);
        cyc(0, 0, 0, 1, 8'hAA, 1, 0, '0);
        chk(0, 1, 0, 0, 1, 0, 1, 1);
        check("a_no_bypass_rd_valid", 32'(a_rd_valid), 0);
        pp(0, 8'hAA);
        chk(0, 0, 1, 0, 1, 0, 1, 1);

        // A: rst clears sticky errors and data_out
        cyc(0, 1, 0, 0, '0, 0, 0, '0);
        chk(0, 0, 1, 0, 1, 0, 0, 0);
        check("a_rst2_data_out", 32'(a_dout), 0);

        // B: offset pointers, then fill 5 across the wrap and drain
        psh(1, 8'hD1); psh(1, 8'hD2);
        pp(1, 8'hD1); pp(1, 8'hD2);
        psh(1, 8'hC1); psh(1, 8'hC2); psh(1, 8'hC3);
        chk(1, 3, 0, 0, 0, 0, 0, 0);
        psh(1, 8'hC4); chk(1, 4, 0, 0, 0, 1, 0, 0);
        psh(1, 8'hC5); chk(1, 5, 0, 1, 0, 1, 0, 0);
        pp(1, 8'hC1); pp(1, 8'hC2); pp(1, 8'hC3); pp(1, 8'hC4); pp(1, 8'hC5);
        chk(1, 0, 1, 0, 1, 0, 0, 0);

        // B: rst mid-fill with a concurrent push
        psh(1, 8'hE1); psh(1, 8'hE2);
        cyc(1, 1, 0, 1, 8'hE3, 0, 0, '0);
        chk(1, 0, 1, 0, 1, 0, 0, 0);
        check("b_rst_mid_rd_valid", 32'(b_rd_valid), 0);
        check("b_rst_mid_data_out", 32'(b_dout), 0);
        psh(1, 8'hF1); pp(1, 8'hF1);
        chk(1, 0, 1, 0, 1, 0, 0, 0);

        cyc(0, 0, 0, 0, '0, 0, 0, '0);
        cyc(1, 0, 0, 0, '0, 0, 0, '0);
        check("a_scoreboard_drained", qa.size(), 0);
        check("b_scoreboard_drained", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
